// File: rtl/mix_columns_seq_if.sv
// Handshake and data bundle for the iterative MixColumns engine.
// The master side feeds states in and takes results; the slave side is the engine.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, in_inv, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, in_inv, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define MIXCOL_INV_EN to build the inverse datapath; otherwise in_inv is ignored.
//
// state  | meaning
// IDLE   | waiting for an input state, in_ready=1
// BUSY   | transforming columns in place, one group per clock
// DONE   | result held on state_out until out_ready; may accept the next input
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mix_columns_seq_if.slave bus
);

  localparam int         NCYC     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_work;
  logic [127:0] w_work_next;
  logic [1:0]   r_cnt;
  logic         w_in_ready;
  logic         w_accept;
`ifdef MIXCOL_INV_EN
  logic         r_inv;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                         ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

`ifdef MIXCOL_INV_EN
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xtime(a[r]);
      m4[r] = xtime(m2[r]);
      m8[r] = xtime(m4[r]);
    end
    // 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = (m8[r] ^ m4[r] ^ m2[r])
                       ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                       ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                       ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return res;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.in_valid) w_next = S_BUSY;
      S_BUSY: if (r_cnt == LAST_CNT) w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = bus.in_valid ? S_BUSY : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready    = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.state_out = '0;
    unique case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_BUSY: bus.busy = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.state_out = r_work;
        w_in_ready    = bus.out_ready;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  assign bus.in_ready = w_in_ready;
  assign w_accept     = bus.in_valid & w_in_ready;

  // Column c belongs to group c/COLS_PER_CYCLE, transformed when the counter reaches it.
  always_comb begin
    w_work_next = r_work;
    for (int c = 0; c < 4; c++) begin
      if (r_cnt == 2'(c / COLS_PER_CYCLE)) begin
`ifdef MIXCOL_INV_EN
        w_work_next[127-32*c -: 32] = r_inv ? mix_inv(r_work[127-32*c -: 32])
                                            : mix_fwd(r_work[127-32*c -: 32]);
`else
        w_work_next[127-32*c -: 32] = mix_fwd(r_work[127-32*c -: 32]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
`ifdef MIXCOL_INV_EN
      r_inv  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work <= bus.state_in;
      r_cnt  <= '0;
`ifdef MIXCOL_INV_EN
      r_inv  <= bus.in_inv;
`endif
    end else if (r_state == S_BUSY) begin
      r_work <= w_work_next;
      r_cnt  <= (r_cnt == LAST_CNT) ? 2'd0 : r_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: runs the 1/2/4 column variants side by side in lockstep
// against a GF(2^8) reference model; honours MIXCOL_INV_EN for the expected mode.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         tb_valid = 1'b0;
  logic         tb_inv = 1'b0;
  logic         tb_oready = 1'b0;
  logic [127:0] tb_state = '0;

  mix_columns_seq_if if1 ();
  mix_columns_seq_if if2 ();
  mix_columns_seq_if if4 ();

  assign if1.in_valid = tb_valid;  assign if1.in_inv = tb_inv;
  assign if1.state_in = tb_state;  assign if1.out_ready = tb_oready;
  assign if2.in_valid = tb_valid;  assign if2.in_inv = tb_inv;
  assign if2.state_in = tb_state;  assign if2.out_ready = tb_oready;
  assign if4.in_valid = tb_valid;  assign if4.in_inv = tb_inv;
  assign if4.state_in = tb_state;  assign if4.out_ready = tb_oready;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic [2:0]   ov, ir, bs;
  logic [127:0] so [3];
  assign ov = {if4.out_valid, if2.out_valid, if1.out_valid};
  assign ir = {if4.in_ready, if2.in_ready, if1.in_ready};
  assign bs = {if4.busy, if2.busy, if1.busy};
  assign so[0] = if1.state_out;
  assign so[1] = if2.state_out;
  assign so[2] = if4.state_out;

  int checks = 0;
  int errors = 0;
  int cols [3] = '{1, 2, 4};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0] co [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] res = '0;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(co[k], a[(r+k)%4]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic eff_inv(input logic inv);
`ifdef MIXCOL_INV_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  // Present an input at the next negedge and step through the acceptance edge.
  task automatic start(input logic [127:0] st, input logic inv, input logic ordy);
    @(negedge clk);
    tb_valid = 1'b1; tb_state = st; tb_inv = inv; tb_oready = ordy;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("in_ready_c%0d", cols[i]), ir[i], 1'b1);
    @(posedge clk);
  endtask

  // Called just after the acceptance edge; checks latency and the held result.
  task automatic finish(input logic [127:0] exp, input string tag);
    int edges;
    int first [3];
    #1;
    tb_valid = 1'b0; tb_oready = 1'b0; tb_inv = ~tb_inv;
    tb_state = {$urandom, $urandom, $urandom, $urandom};
    edges = 1;
    first = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_busy_c%0d", tag, cols[i]), bs[i], 1'b1);
      chk($sformatf("%s_early_valid_c%0d", tag, cols[i]), ov[i], 1'b0);
    end
    while (edges < 6) begin
      @(posedge clk);
      #1;
      edges++;
      for (int i = 0; i < 3; i++) if (ov[i] && first[i] == 0) first[i] = edges;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_latency_c%0d", tag, cols[i]), 128'(first[i]), 128'(4 / cols[i] + 1));
      chk($sformatf("%s_data_c%0d", tag, cols[i]), so[i], exp);
      chk($sformatf("%s_valid_c%0d", tag, cols[i]), ov[i], 1'b1);
      chk($sformatf("%s_stall_ready_c%0d", tag, cols[i]), ir[i], 1'b0);
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    tb_oready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_idle_valid_c%0d", tag, cols[i]), ov[i], 1'b0);
      chk($sformatf("%s_idle_ready_c%0d", tag, cols[i]), ir[i], 1'b1);
      chk($sformatf("%s_idle_busy_c%0d", tag, cols[i]), bs[i], 1'b0);
    end
    tb_oready = 1'b0;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    logic [127:0] st, exp, st2, exp2;
    logic inv;

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid_c%0d", cols[i]), ov[i], 1'b0);
      chk($sformatf("rst_ready_c%0d", cols[i]), ir[i], 1'b1);
      chk($sformatf("rst_busy_c%0d", cols[i]), bs[i], 1'b0);
      chk($sformatf("rst_data_c%0d", cols[i]), so[i], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    start(FIPS_IN, 1'b0, 1'b0);
    finish(FIPS_OUT, "fips_fwd");
    release_out("fips_fwd");

    start(FIPS_OUT, 1'b1, 1'b0);
`ifdef MIXCOL_INV_EN
    finish(FIPS_IN, "fips_inv");
`else
    finish(ref_mix(FIPS_OUT, 1'b0), "fips_inv");
`endif
    release_out("fips_inv");

    start(128'h01010101c6c6c6c6db135345f20a225c, 1'b0, 1'b0);
    finish(128'h01010101c6c6c6c68e4da1bc9fdc589d, "fixed_pt");
    release_out("fixed_pt");

    start({128{1'b1}}, 1'b0, 1'b0);
    finish({128{1'b1}}, "all_ff");
    release_out("all_ff");

    // in_inv=1 on the forward vector: forward result when the inverse path is absent
    start(FIPS_IN, 1'b1, 1'b0);
`ifdef MIXCOL_INV_EN
    finish(ref_mix(FIPS_IN, 1'b1), "inv_flag");
`else
    finish(FIPS_OUT, "inv_flag");
`endif
    release_out("inv_flag");

    for (int k = 0; k < 6; k++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      exp = ref_mix(st, eff_inv(inv));
      start(st, inv, 1'b0);
      finish(exp, $sformatf("rand%0d", k));
      release_out($sformatf("rand%0d", k));
    end

    st   = {$urandom, $urandom, $urandom, $urandom};
    exp  = ref_mix(st, 1'b0);
    st2  = {$urandom, $urandom, $urandom, $urandom};
    exp2 = ref_mix(st2, 1'b0);
    start(st, 1'b0, 1'b0);
    finish(exp, "bp_first");
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_hold_data_c%0d", cols[i]), so[i], exp);
        chk($sformatf("bp_hold_ready_c%0d", cols[i]), ir[i], 1'b0);
      end
    end
    start(st2, 1'b0, 1'b1);
    finish(exp2, "bp_b2b");
    release_out("bp_b2b");

    start(FIPS_IN, 1'b0, 1'b0);
    #1;
    tb_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_valid_c%0d", cols[i]), ov[i], 1'b0);
      chk($sformatf("abort_ready_c%0d", cols[i]), ir[i], 1'b1);
      chk($sformatf("abort_busy_c%0d", cols[i]), bs[i], 1'b0);
      chk($sformatf("abort_data_c%0d", cols[i]), so[i], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(FIPS_IN, 1'b0, 1'b0);
    finish(FIPS_OUT, "post_rst");
    release_out("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
